// File: rtl/pwm_led_bank_if.sv
// rtl/pwm_led_bank_if.sv - period request and per-channel write bus for pwm_led_bank
interface pwm_led_bank_if #(
  parameter int CNT_W = 8,
  parameter int CH_W  = 2
);
  logic [CNT_W-1:0] period;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_duty;
  logic             wr_breathe;

  modport master (output period, wr_en, wr_ch, wr_duty, wr_breathe);
  modport slave  (input  period, wr_en, wr_ch, wr_duty, wr_breathe);
endinterface

// File: rtl/pwm_led_bank.sv
// rtl/pwm_led_bank.sv - multi-channel PWM LED driver with shared period counter
// Duty and mode writes land in shadows and are applied only at period wrap.
module pwm_led_bank #(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 8,
  parameter int PERIOD_DEFAULT = 100,
  parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pwm_led_bank_if.slave       bus,
  output logic [CHANNELS-1:0] o_led,
  output logic                o_period_tick
);

  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_period;
  logic [CNT_W-1:0]    r_sh_duty [CHANNELS];
  logic [CNT_W-1:0]    r_duty    [CHANNELS];
  logic [CHANNELS-1:0] r_sh_mode;
  logic [CHANNELS-1:0] r_dir;          // 1 = ramping down

  logic                w_wrap;
  logic [CNT_W-1:0]    w_next_duty [CHANNELS];
  logic [CHANNELS-1:0] w_next_dir;

  assign w_wrap = (r_period <= CNT_W'(1)) || (r_cnt == r_period - CNT_W'(1));

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_next_duty[i] = r_sh_duty[i];
      w_next_dir[i]  = r_dir[i];
      if (r_sh_mode[i]) begin
        if (r_duty[i] > r_sh_duty[i]) begin
          w_next_duty[i] = r_sh_duty[i];
          w_next_dir[i]  = 1'b1;
        end else if (!r_dir[i]) begin
          if (r_duty[i] < r_sh_duty[i]) begin
            w_next_duty[i] = r_duty[i] + CNT_W'(1);
            if (r_duty[i] + CNT_W'(1) == r_sh_duty[i]) w_next_dir[i] = 1'b1;
          end else if (r_sh_duty[i] != '0) begin
            // Already at the ceiling while heading up: turn around.
            w_next_duty[i] = r_duty[i] - CNT_W'(1);
            w_next_dir[i]  = (r_duty[i] != CNT_W'(1));
          end else begin
            w_next_duty[i] = '0;
          end
        end else begin
          if (r_duty[i] != '0) begin
            w_next_duty[i] = r_duty[i] - CNT_W'(1);
            if (r_duty[i] == CNT_W'(1)) w_next_dir[i] = 1'b0;
          end else begin
            w_next_duty[i] = '0;
            w_next_dir[i]  = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_period  <= CNT_W'(PERIOD_DEFAULT);
      r_sh_mode <= '0;
      r_dir     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_sh_duty[i] <= '0;
        r_duty[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.wr_en && (int'(bus.wr_ch) == i)) begin
          r_sh_duty[i] <= bus.wr_duty;
          r_sh_mode[i] <= bus.wr_breathe;
        end
      end
      if (w_wrap) begin
        r_cnt    <= '0;
        r_period <= bus.period;
        r_dir    <= w_next_dir;
        for (int i = 0; i < CHANNELS; i++) r_duty[i] <= w_next_duty[i];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) o_led[i] = (r_cnt < r_duty[i]);
    o_period_tick = w_wrap;
  end

endmodule

// File: tb/tb_pwm_led_bank.sv
// tb/tb_pwm_led_bank.sv - directed self-checking bench for pwm_led_bank
module tb_pwm_led_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] led;
  logic       tick;
  int         compared = 0;
  int         mismatched = 0;

  pwm_led_bank_if #(.CNT_W(8), .CH_W(3)) bus ();

  pwm_led_bank #(
    .CHANNELS(4), .CNT_W(8), .PERIOD_DEFAULT(100), .CH_W(3)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .o_led(led), .o_period_tick(tick)
  );

  always #5 clk = ~clk;

  typedef logic [3:0][7:0] quad_t;
  typedef struct {
    quad_t wduty;
    quad_t exp_high;
  } vec_t;

  vec_t vecs [3];

  function automatic quad_t mk(int a, int b, int c, int d);
    quad_t q;
    q[0] = 8'(a); q[1] = 8'(b); q[2] = 8'(c); q[3] = 8'(d);
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int ch, input int d, input bit b);
    bus.wr_en      = 1'b1;
    bus.wr_ch      = 3'(ch);
    bus.wr_duty    = 8'(d);
    bus.wr_breathe = b;
    step();
    bus.wr_en      = 1'b0;
  endtask

  task automatic wait_wrap(input string name);
    for (int n = 0; n < 300; n++) begin
      if (tick) begin
        step();
        return;
      end
      step();
    end
    chk({name, " wrap timeout"}, 0, 1);
  endtask

  // Walks the current period from cnt=k0 to its end; expects led[i] high while cnt < exp[i].
  task automatic measure(input string name, input int k0, input int p, input quad_t exp);
    int bad [4];
    int tbad;
    tbad = 0;
    for (int i = 0; i < 4; i++) bad[i] = 0;
    for (int k = k0; k < p; k++) begin
      for (int i = 0; i < 4; i++)
        if (led[i] !== (k < int'(exp[i]))) bad[i]++;
      if (tick !== (k == p - 1)) tbad++;
      step();
    end
    for (int i = 0; i < 4; i++) chk($sformatf("%s led%0d bad cycles", name, i), bad[i], 0);
    chk({name, " tick bad cycles"}, tbad, 0);
  endtask

  int ramp1 [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
  int ramp2 [6] = '{2, 1, 0, 1, 2, 1};

  initial begin
    int bad;
    int tbad;
    bus.period = 8'd100;
    bus.wr_en = 1'b0;
    bus.wr_ch = '0;
    bus.wr_duty = '0;
    bus.wr_breathe = 1'b0;

    vecs[0].wduty = mk(0, 255, 100, 1);  vecs[0].exp_high = mk(0, 100, 100, 1);
    vecs[1].wduty = mk(99, 50, 0, 7);    vecs[1].exp_high = mk(99, 50, 0, 7);
    vecs[2].wduty = mk(20, 40, 60, 80);  vecs[2].exp_high = mk(20, 40, 60, 80);

    step();
    rst = 1'b0;
    chk("reset led", int'(led), 0);
    chk("reset tick", int'(tick), 0);

    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 4; i++) wr(i, int'(vecs[v].wduty[i]), 1'b0);
      wr(5, 33, 1'b1);
      wait_wrap($sformatf("vec%0d", v));
      measure($sformatf("vec%0d", v), 0, 100, vecs[v].exp_high);
    end

    // Mid-period write must not disturb the running period.
    for (int k = 0; k < 30; k++) step();
    wr(2, 10, 1'b0);
    bad = 0;
    for (int k = 31; k < 100; k++) begin
      if (led[2] !== (k < 60)) bad++;
      step();
    end
    chk("midwrite old period led2 bad", bad, 0);
    measure("midwrite new", 0, 100, mk(20, 40, 10, 80));

    for (int k = 0; k < 50; k++) step();
    bus.period = 8'd10;
    tbad = 0;
    for (int k = 50; k < 100; k++) begin
      if (tick !== (k == 99)) tbad++;
      step();
    end
    chk("period change old tick bad", tbad, 0);
    measure("p10 a", 0, 10, mk(10, 10, 10, 10));
    measure("p10 b", 0, 10, mk(10, 10, 10, 10));

    bus.period = 8'd0;
    wait_wrap("p0");
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (tick !== 1'b1 || led !== 4'hF) bad++;
      step();
    end
    chk("p0 tick/led bad", bad, 0);
    wr(0, 0, 1'b0);
    chk("p0 shadow not yet active", int'(led), 15);
    step();
    chk("p0 duty0 applied", int'(led), 14);

    bus.period = 8'd10;
    step();
    wr(3, 0, 1'b0);
    wait_wrap("breathe prep");
    wr(3, 4, 1'b1);
    measure("breathe pre", 1, 10, mk(0, 10, 10, 0));
    for (int j = 0; j < 9; j++)
      measure($sformatf("ramp4 %0d", j), 0, 10, mk(0, 10, 10, ramp1[j]));
    measure("ramp4 9", 0, 10, mk(0, 10, 10, 2));
    measure("ramp4 10", 0, 10, mk(0, 10, 10, 3));
    wr(3, 2, 1'b1);
    measure("ramp4 top", 1, 10, mk(0, 10, 10, 4));
    for (int j = 0; j < 6; j++)
      measure($sformatf("ramp2 %0d", j), 0, 10, mk(0, 10, 10, ramp2[j]));

    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset led", int'(led), 0);
    chk("midreset tick", int'(tick), 0);
    bad = 0;
    tbad = 0;
    for (int k = 0; k < 100; k++) begin
      if (led !== 4'h0) bad++;
      if (tick !== (k == 99)) tbad++;
      step();
    end
    chk("postreset led bad", bad, 0);
    chk("postreset tick bad", tbad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
